// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-access stage with req/ack data bus; optional ack watchdog under MEM_TIMEOUT_EN
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        ld_q, ld_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic [4:0]  wdl_q, wdl_d;
  logic        wrl_q, wrl_d;
  logic        req_d, we_d;
  logic [31:0] addr_d, bwd_d;
  logic [3:0]  sel_d;
  logic [4:0]  wd_d;
  logic        wreg_d;
  logic [31:0] wdata_d;
  logic        mis_d;
  logic        err_d;

  logic        is_load, is_store, is_uns, aligned;
  logic [1:0]  size;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

`ifdef MEM_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus_err_o = 1'b0;
`endif

  // Decode the memory op class, access size (0 byte, 1 half, 2 word) and alignment
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_uns   = 1'b0;
    size     = 2'd0;
    case (aluop_i)
      OP_LB:  is_load = 1'b1;
      OP_LBU: begin is_load = 1'b1; is_uns = 1'b1; end
      OP_LH:  begin is_load = 1'b1; size = 2'd1; end
      OP_LHU: begin is_load = 1'b1; is_uns = 1'b1; size = 2'd1; end
      OP_LW:  begin is_load = 1'b1; size = 2'd2; end
      OP_SB:  is_store = 1'b1;
      OP_SH:  begin is_store = 1'b1; size = 2'd1; end
      OP_SW:  begin is_store = 1'b1; size = 2'd2; end
      default: ;
    endcase
    aligned = (size == 2'd0) ||
              (size == 2'd1 && !wdata_i[0]) ||
              (size == 2'd2 && wdata_i[1:0] == 2'b00);
  end

  // Pick the big-endian lane of the returned word and extend it per the latched op
  always_comb begin
    case (lo_q)
      2'b00:   lane_b = bus_rdata_i[31:24];
      2'b01:   lane_b = bus_rdata_i[23:16];
      2'b10:   lane_b = bus_rdata_i[15:8];
      default: lane_b = bus_rdata_i[7:0];
    endcase
    lane_h = lo_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (size_q)
      2'd0:    load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = bus_rdata_i;
    endcase
  end

  // Next-state, stall and next register values; outputs default to a bubble
  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    uns_d      = uns_q;
    size_d     = size_q;
    lo_d       = lo_q;
    wdl_d      = wdl_q;
    wrl_d      = wrl_q;
    req_d      = bus_req_o;
    we_d       = bus_we_o;
    addr_d     = bus_addr_o;
    sel_d      = bus_sel_o;
    bwd_d      = bus_wdata_o;
    wd_d       = 5'd0;
    wreg_d     = 1'b0;
    wdata_d    = 32'd0;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    stallreq_o = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (is_load || is_store) begin
          if (aligned) begin
            stallreq_o = 1'b1;
            state_d    = S_WAIT;
            ld_d       = is_load;
            uns_d      = is_uns;
            size_d     = size;
            lo_d       = wdata_i[1:0];
            wdl_d      = wd_i;
            wrl_d      = wreg_i;
            req_d      = 1'b1;
            we_d       = is_store;
            addr_d     = {wdata_i[31:2], 2'b00};
            case (size)
              2'd0:    sel_d = 4'b1000 >> wdata_i[1:0];
              2'd1:    sel_d = wdata_i[1] ? 4'b0011 : 4'b1100;
              default: sel_d = 4'b1111;
            endcase
            if (!is_store)        bwd_d = 32'd0;
            else if (size == 2'd0) bwd_d = {4{reg2_i[7:0]}};
            else if (size == 2'd1) bwd_d = {2{reg2_i[15:0]}};
            else                   bwd_d = reg2_i;
`ifdef MEM_TIMEOUT_EN
            cnt_d = 32'd0;
`endif
          end else begin
            mis_d = 1'b1;
          end
        end else begin
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end
      end
      S_WAIT: begin
        if (bus_ack_i) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'd0;
          sel_d   = 4'd0;
          bwd_d   = 32'd0;
          if (ld_q) begin
            wd_d    = wdl_q;
            wreg_d  = wrl_q;
            wdata_d = load_val;
          end
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = 32'd0;
            sel_d   = 4'd0;
            bwd_d   = 32'd0;
            err_d   = 1'b1;
          end else begin
            cnt_d      = cnt_q + 32'd1;
            stallreq_o = 1'b1;
          end
`else
          stallreq_o = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched transaction and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ld_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      lo_q        <= 2'd0;
      wdl_q       <= 5'd0;
      wrl_q       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_sel_o   <= 4'd0;
      bus_wdata_o <= 32'd0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'd0;
      misalign_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      wdl_q       <= wdl_d;
      wrl_q       <= wrl_d;
      bus_req_o   <= req_d;
      bus_we_o    <= we_d;
      bus_addr_o  <= addr_d;
      bus_sel_o   <= sel_d;
      bus_wdata_o <= bwd_d;
      wd_o        <= wd_d;
      wreg_o      <= wreg_d;
      wdata_o     <= wdata_d;
      misalign_o  <= mis_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Ack watchdog counter and its timeout pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 32'd0;
      bus_err_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_o <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;
  localparam logic [7:0] OP_OR  = 8'b00100101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop = 8'd0;
  logic [4:0]  wd = 5'd0;
  logic        wreg = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] reg2 = 32'd0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, misalign_o, bus_req_o, bus_we_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;

  int total = 0;
  int bad = 0;

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdata), .reg2_i(reg2), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nop_in();
    aluop = 8'd0; wd = 5'd0; wreg = 1'b0; wdata = 32'd0; reg2 = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; nop_in(); bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({wd_o, wreg_o, wdata_o, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o,
         bus_wdata_o, misalign_o, bus_err_o} !== 112'd0) begin
      bad++; $display("FAIL reset_outputs got wd=%0d wreg=%0b wdata=%h req=%0b sel=%b", wd_o, wreg_o, wdata_o, bus_req_o, bus_sel_o);
    end
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    aluop = OP_OR; wd = 5'd3; wreg = 1'b1; wdata = 32'h0000F0F0;
    #1;
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL pass_stall got=%b exp=0", stallreq_o); end
    @(negedge clk);
    total++;
    if ({wd_o, wreg_o, wdata_o} !== {5'd3, 1'b1, 32'h0000F0F0}) begin
      bad++; $display("FAIL pass_or got wd=%0d wreg=%b wdata=%h exp wd=3 wreg=1 wdata=0000f0f0", wd_o, wreg_o, wdata_o);
    end
    aluop = 8'b11100010; wd = 5'd31; wreg = 1'b0; wdata = 32'hFFFFFFFF;
    #1;
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL pass_nearop_stall got=%b exp=0", stallreq_o); end
    @(negedge clk);
    total++;
    if ({wd_o, wreg_o, wdata_o, bus_req_o} !== {5'd31, 1'b0, 32'hFFFFFFFF, 1'b0}) begin
      bad++; $display("FAIL pass_nearop got wd=%0d wreg=%b wdata=%h req=%b exp wd=31 wreg=0 wdata=ffffffff req=0", wd_o, wreg_o, wdata_o, bus_req_o);
    end
    nop_in();
  endtask

  task automatic test_load_byte();
    logic [7:0]  ops [2];
    logic [31:0] exps [2];
    int stalls;
    ops[0] = OP_LB;  exps[0] = 32'hFFFFFF80;
    ops[1] = OP_LBU; exps[1] = 32'h00000080;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      aluop = ops[i]; wd = 5'd7; wreg = 1'b1; wdata = 32'h00000101;
      stalls = 0;
      #1 if (stallreq_o) stalls++;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        total++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, wreg_o} !== {1'b1, 1'b0, 32'h00000100, 4'b0100, 1'b0}) begin
          bad++; $display("FAIL lb_bus op=%h k=%0d got req=%b we=%b addr=%h sel=%b wreg=%b exp 1 0 00000100 0100 0", ops[i], k, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, wreg_o);
        end
        if (k == 4) begin bus_ack = 1'b1; bus_rdata = 32'h1280FF00; end
        #1 if (stallreq_o) stalls++;
      end
      @(negedge clk);
      total++;
      if (stalls !== 4) begin bad++; $display("FAIL lb_stall_cycles op=%h got=%0d exp=4", ops[i], stalls); end
      total++;
      if ({wdata_o, wreg_o, wd_o, bus_req_o} !== {exps[i], 1'b1, 5'd7, 1'b0}) begin
        bad++; $display("FAIL lb_result op=%h got wdata=%h wreg=%b wd=%0d req=%b exp wdata=%h wreg=1 wd=7 req=0", ops[i], wdata_o, wreg_o, wd_o, bus_req_o, exps[i]);
      end
      bus_ack = 1'b0; bus_rdata = 32'd0; nop_in();
    end
  endtask

  task automatic test_store_half();
    @(negedge clk);
    aluop = OP_SH; wd = 5'd9; wreg = 1'b1; wdata = 32'h00000202; reg2 = 32'h0000BEEF;
    #1;
    total++;
    if (stallreq_o !== 1'b1) begin bad++; $display("FAIL sh_stall got=%b exp=1", stallreq_o); end
    @(negedge clk);
    total++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {1'b1, 1'b1, 32'h00000200, 4'b0011, 32'hBEEFBEEF}) begin
      bad++; $display("FAIL sh_bus got req=%b we=%b addr=%h sel=%b wdata=%h exp 1 1 00000200 0011 beefbeef", bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
    end
    bus_ack = 1'b1;
    #1;
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL sh_ack_stall got=%b exp=0", stallreq_o); end
    @(negedge clk);
    total++;
    if ({wreg_o, wdata_o, bus_req_o} !== {1'b0, 32'd0, 1'b0}) begin
      bad++; $display("FAIL sh_done got wreg=%b wdata=%h req=%b exp 0 0 0", wreg_o, wdata_o, bus_req_o);
    end
    bus_ack = 1'b0; nop_in();
  endtask

  task automatic test_misalign();
    logic [7:0]  ops [2];
    logic [31:0] addrs [2];
    ops[0] = OP_LW; addrs[0] = 32'h00000006;
    ops[1] = OP_SH; addrs[1] = 32'h00000201;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      aluop = ops[i]; wd = 5'd4; wreg = 1'b1; wdata = addrs[i];
      #1;
      total++;
      if (stallreq_o !== 1'b0) begin bad++; $display("FAIL mis_stall op=%h got=%b exp=0", ops[i], stallreq_o); end
      @(negedge clk);
      total++;
      if ({misalign_o, bus_req_o, wreg_o} !== 3'b100) begin
        bad++; $display("FAIL mis_pulse op=%h got mis=%b req=%b wreg=%b exp 1 0 0", ops[i], misalign_o, bus_req_o, wreg_o);
      end
      nop_in();
      @(negedge clk);
      total++;
      if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_once op=%h got=%b exp=0", ops[i], misalign_o); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    aluop = OP_LW; wd = 5'd5; wreg = 1'b1; wdata = 32'h00000020;
    @(negedge clk);
    total++;
    if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%b exp=1", bus_req_o); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rmid_async_drop got=%b exp=0", bus_req_o); end
    nop_in();
    @(negedge clk);
    rst = 1'b1;
    aluop = OP_SW; wd = 5'd1; wreg = 1'b0; wdata = 32'h00000010; reg2 = 32'hCAFEF00D;
    #1;
    total++;
    if (stallreq_o !== 1'b1) begin bad++; $display("FAIL rmid_sw_stall got=%b exp=1", stallreq_o); end
    @(negedge clk);
    total++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {1'b1, 1'b1, 32'h00000010, 4'b1111, 32'hCAFEF00D}) begin
      bad++; $display("FAIL rmid_sw_bus got req=%b we=%b addr=%h sel=%b wdata=%h exp 1 1 00000010 1111 cafef00d", bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_req_o, wreg_o} !== 2'b00) begin bad++; $display("FAIL rmid_sw_done got req=%b wreg=%b exp 0 0", bus_req_o, wreg_o); end
    bus_ack = 1'b0; nop_in();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    aluop = OP_LW; wd = 5'd10; wreg = 1'b1; wdata = 32'h00000040;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    @(negedge clk);
    total++;
    if ({wdata_o, wd_o, wreg_o} !== {32'h11223344, 5'd10, 1'b1}) begin
      bad++; $display("FAIL b2b_lw got wdata=%h wd=%0d wreg=%b exp 11223344 10 1", wdata_o, wd_o, wreg_o);
    end
    bus_ack = 1'b0;
    aluop = OP_LH; wd = 5'd11; wreg = 1'b1; wdata = 32'h00000040;
    #1;
    total++;
    if (stallreq_o !== 1'b1) begin bad++; $display("FAIL b2b_lh_stall got=%b exp=1", stallreq_o); end
    @(negedge clk);
    total++;
    if ({bus_req_o, bus_addr_o, bus_sel_o} !== {1'b1, 32'h00000040, 4'b1100}) begin
      bad++; $display("FAIL b2b_lh_bus got req=%b addr=%h sel=%b exp 1 00000040 1100", bus_req_o, bus_addr_o, bus_sel_o);
    end
    bus_ack = 1'b1; bus_rdata = 32'h80011234;
    @(negedge clk);
    total++;
    if ({wdata_o, wd_o} !== {32'hFFFF8001, 5'd11}) begin
      bad++; $display("FAIL b2b_lh got wdata=%h wd=%0d exp ffff8001 11", wdata_o, wd_o);
    end
    bus_ack = 1'b0; bus_rdata = 32'd0; nop_in();
  endtask

  task automatic test_ack_in_idle();
    @(negedge clk);
    aluop = OP_OR; wd = 5'd4; wreg = 1'b1; wdata = 32'h00001234;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if (stallreq_o !== 1'b0) begin bad++; $display("FAIL idle_ack_stall got=%b exp=0", stallreq_o); end
    @(negedge clk);
    total++;
    if ({bus_req_o, wdata_o, wd_o} !== {1'b0, 32'h00001234, 5'd4}) begin
      bad++; $display("FAIL idle_ack got req=%b wdata=%h wd=%0d exp 0 00001234 4", bus_req_o, wdata_o, wd_o);
    end
    bus_ack = 1'b0; bus_rdata = 32'd0; nop_in();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int reqs;
    logic exp_stall;
    @(negedge clk);
    aluop = OP_LW; wd = 5'd6; wreg = 1'b1; wdata = 32'h00000080;
    reqs = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus_req_o) reqs++;
      exp_stall = (k < 4);
      #1;
      total++;
      if (stallreq_o !== exp_stall) begin bad++; $display("FAIL to_stall k=%0d got=%b exp=%b", k, stallreq_o, exp_stall); end
    end
    nop_in();
    @(negedge clk);
    total++;
    if ({bus_req_o, bus_err_o, wreg_o} !== 3'b010) begin
      bad++; $display("FAIL to_end got req=%b err=%b wreg=%b exp 0 1 0", bus_req_o, bus_err_o, wreg_o);
    end
    total++;
    if (reqs !== 4) begin bad++; $display("FAIL to_req_cycles got=%0d exp=4", reqs); end
    aluop = OP_OR; wd = 5'd2; wreg = 1'b1; wdata = 32'h00000055;
    @(negedge clk);
    total++;
    if ({bus_err_o, wd_o, wdata_o} !== {1'b0, 5'd2, 32'h00000055}) begin
      bad++; $display("FAIL to_idle got err=%b wd=%0d wdata=%h exp 0 2 00000055", bus_err_o, wd_o, wdata_o);
    end
    nop_in();
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_ack_in_idle();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
